// File: rtl/fetch_pc_redirect.sv
// Fetch PC owner: sequential imem requests, taken branch/jump redirect with IF/ID flush.
// Optional redirect counter port enabled by defining REDIRECT_CNT_EN.
module fetch_pc_redirect #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic [31:0] target_i,
  input  logic        stall_i,
  input  logic        imem_ready_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_if_o,
  output logic        if_valid_o,
  output logic        flush_o,
`ifdef REDIRECT_CNT_EN
  output logic        misalign_o,
  output logic [15:0] redirect_cnt_o
`else
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {StBoot, StFetch, StWait, StFlush} state_e;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_if_q;
  logic        if_valid_q;
  logic        misalign_q;
  logic [2:0]  flush_cnt_q;

  logic redirect;
  logic redirect_applied;

  assign redirect         = branch_i | jump_i;
  assign redirect_applied = redirect && (state_q != StBoot);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      pc_if_q     <= 32'h0;
      if_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      flush_cnt_q <= 3'd0;
    end else begin
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      if (state_q == StBoot) begin
        state_q <= StFetch;
      end else if (redirect) begin
        // Any outstanding request is abandoned; a late imem_ready falls into FLUSH and is ignored.
        pc_q        <= {target_i[31:2], 2'b00};
        state_q     <= StFlush;
        flush_cnt_q <= FlushLoad;
        misalign_q  <= |target_i[1:0];
      end else begin
        unique case (state_q)
          StFlush: begin
            if (flush_cnt_q == 3'd0) begin
              state_q <= StFetch;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
            end
          end
          StFetch, StWait: begin
            if (!stall_i) begin
              if (imem_ready_i) begin
                pc_q       <= pc_q + PC_STEP;
                pc_if_q    <= pc_q;
                if_valid_q <= 1'b1;
                state_q    <= StFetch;
              end else begin
                state_q <= StWait;
              end
            end
          end
          default: state_q <= StFetch;
        endcase
      end
    end
  end

  assign imem_req_o  = (state_q == StFetch) || (state_q == StWait);
  assign imem_addr_o = pc_q;
  assign pc_if_o     = pc_if_q;
  assign if_valid_o  = if_valid_q;
  assign flush_o     = (state_q == StFlush);
  assign misalign_o  = misalign_q;

`ifdef REDIRECT_CNT_EN
  logic [15:0] redirect_cnt_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      redirect_cnt_q <= 16'h0;
    end else if (redirect_applied && (redirect_cnt_q != 16'hFFFF)) begin
      redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// Scoreboard bench for fetch_pc_redirect: a cycle model predicts outputs after each edge,
// a monitor pops and compares. Define REDIRECT_CNT_EN to also cover the redirect counter.
module tb_fetch_pc_redirect;

  localparam int FLUSH_N = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        branch = 1'b0, jump = 1'b0, stall = 1'b0, imem_ready = 1'b0;
  logic [31:0] target = 32'h0;
  logic        imem_req, if_valid, flush, misalign;
  logic [31:0] imem_addr, pc_if;
  logic [15:0] redirect_cnt;

  always #5 clk = ~clk;

  fetch_pc_redirect dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .branch_i       (branch),
    .jump_i         (jump),
    .target_i       (target),
    .stall_i        (stall),
    .imem_ready_i   (imem_ready),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .pc_if_o        (pc_if),
    .if_valid_o     (if_valid),
    .flush_o        (flush),
`ifdef REDIRECT_CNT_EN
    .misalign_o     (misalign),
    .redirect_cnt_o (redirect_cnt)
`else
    .misalign_o     (misalign)
`endif
  );

`ifndef REDIRECT_CNT_EN
  assign redirect_cnt = 16'h0;
`endif

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc_if;
    logic        if_valid;
    logic        flush;
    logic        misalign;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: plain variables describing what the fetch unit is doing.
  bit          m_boot = 1'b1;
  int          m_flush_left = 0;
  logic [31:0] m_pc = 32'h0, m_pc_if = 32'h0;
  bit          m_if_valid = 1'b0, m_misalign = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.req      = !m_boot && (m_flush_left == 0);
    e.addr     = m_pc;
    e.pc_if    = m_pc_if;
    e.if_valid = m_if_valid;
    e.flush    = (m_flush_left > 0);
    e.misalign = m_misalign;
    e.cnt      = 16'(m_cnt);
    return e;
  endfunction

  task automatic model_step(input logic rn, input logic br, input logic jp,
                            input logic [31:0] tg, input logic st, input logic rd);
    if (!rn) begin
      m_boot = 1; m_flush_left = 0; m_pc = 32'h0; m_pc_if = 32'h0;
      m_if_valid = 0; m_misalign = 0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 0; m_if_valid = 0; m_misalign = 0;
    end else if (br || jp) begin
      m_pc = tg & 32'hFFFF_FFFC;
      m_flush_left = FLUSH_N;
      m_if_valid = 0;
      m_misalign = (tg[1:0] != 2'b00);
      if (m_cnt < 65535) m_cnt++;
    end else if (m_flush_left > 0) begin
      m_flush_left--; m_if_valid = 0; m_misalign = 0;
    end else begin
      m_misalign = 0;
      m_if_valid = 0;
      if (!st && rd) begin
        m_pc_if = m_pc;
        m_pc = m_pc + 32'd4;
        m_if_valid = 1;
      end
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic cyc(input logic rn, input logic br, input logic jp, input logic [31:0] tg,
                     input logic st, input logic rd);
    @(negedge clk);
    #1;
    reset_n = rn; branch = br; jump = jp; target = tg; stall = st; imem_ready = rd;
    model_step(rn, br, jp, tg, st, rd);
    exp_q.push_back(model_out());
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imem_req", 32'(imem_req), 32'(e.req));
      chk("imem_addr", imem_addr, e.addr);
      chk("pc_if", pc_if, e.pc_if);
      chk("if_valid", 32'(if_valid), 32'(e.if_valid));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("misalign", 32'(misalign), 32'(e.misalign));
`ifdef REDIRECT_CNT_EN
      chk("redirect_cnt", 32'(redirect_cnt), 32'(e.cnt));
`endif
    end
  end

  initial begin
    #1;
    chk("reset_req", 32'(imem_req), 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_flush", 32'(flush), 32'h0);
    chk("reset_if_valid", 32'(if_valid), 32'h0);

    repeat (2) cyc(0, 0, 0, 32'h0, 0, 1);
    // Boot, then addresses 0,4,8,C.
    repeat (4) cyc(1, 0, 0, 32'h0, 0, 1);
    cyc(1, 1, 0, 32'h100, 0, 1);
    repeat (4) cyc(1, 0, 0, 32'h0, 0, 1);
    // Jump during stall, misaligned target.
    cyc(1, 0, 1, 32'h203, 1, 1);
    repeat (4) cyc(1, 0, 0, 32'h0, 0, 1);
    // Wait states at 0x40.
    cyc(1, 0, 1, 32'h40, 0, 1);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 0);
    repeat (3) cyc(1, 0, 0, 32'h0, 0, 0);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 1);
    chk("wait_accept_pc_if", pc_if, 32'h40);
    // Redirect in WAIT with a late ready.
    cyc(1, 0, 0, 32'h0, 0, 0);
    cyc(1, 1, 0, 32'h80, 0, 0);
    repeat (4) cyc(1, 0, 0, 32'h0, 0, 1);
    // Redirect during first flush cycle restarts the flush.
    cyc(1, 0, 1, 32'h280, 0, 1);
    cyc(1, 0, 1, 32'h300, 0, 1);
    repeat (4) cyc(1, 0, 0, 32'h0, 0, 1);
    // PC wrap at 2^32.
    cyc(1, 0, 1, 32'hFFFF_FFFC, 0, 1);
    repeat (4) cyc(1, 0, 0, 32'h0, 0, 1);
    // Reset in the middle of a flush.
    cyc(1, 0, 1, 32'h500, 0, 1);
    @(negedge clk);
    #1;
    reset_n = 1'b0; jump = 1'b0;
    #1;
    chk("midflush_reset_flush", 32'(flush), 32'h0);
    chk("midflush_reset_addr", imem_addr, 32'h0);
    model_step(0, 0, 0, 32'h0, 0, 1);
    exp_q.push_back(model_out());
    cyc(0, 0, 0, 32'h0, 0, 1);
    repeat (3) cyc(1, 0, 0, 32'h0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rn, br, jp, st, rd;
      rn = ($urandom_range(0, 299) != 0);
      br = ($urandom_range(0, 9) == 0);
      jp = ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 3) != 0);
      cyc(rn, br, jp, $urandom(), st, rd);
    end

`ifdef REDIRECT_CNT_EN
    cyc(0, 0, 0, 32'h0, 0, 1);
    repeat (3) cyc(1, 0, 0, 32'h0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 1, 32'h600, 0, 1);
      repeat (4) cyc(1, 0, 0, 32'h0, 0, 1);
    end
    chk("cnt_three", 32'(redirect_cnt), 32'd3);
    // Back-to-back redirects drive the counter into saturation.
    for (int k = 0; k < 65540; k++) cyc(1, 0, 1, 32'h700, 0, 1);
    repeat (4) cyc(1, 0, 0, 32'h0, 0, 1);
    chk("cnt_saturated", 32'(redirect_cnt), 32'h0000_FFFF);
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
